// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller sharing one 7-segment decoder among N_DIGITS digits.
// Optional leading-zero blanking is enabled by defining DISPLAY_SCAN_LZB_EN.
module display_scan_ctrl #(
   parameter int N_DIGITS     = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*N_DIGITS-1:0] data_in,
   input  logic                  data_valid,
   output logic                  data_ready,
   output logic [3:0]            digit_code,
   output logic [N_DIGITS-1:0]   anodes,
   output logic                  frame_start
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = $clog2(N_DIGITS);
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLANK_C  = CW'(BLANK_CYCLES);
   localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

   typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

   // Handshake: a transfer happens on a rising clk edge where data_valid && data_ready.
   // data_ready mirrors ~pending_full; the upstream holds data_in while ready is low.

   logic                  running;
   logic [CW-1:0]         cnt, cnt_nxt;
   logic [IW-1:0]         idx, idx_nxt;
   state_t                state, state_nxt;
   logic [4*N_DIGITS-1:0] active, active_nxt;
   logic [4*N_DIGITS-1:0] pending;
   logic                  pending_full, pending_full_nxt;
   logic                  slot_wrap, frame_wrap, commit, accept;
   logic [N_DIGITS-1:0]   supp;
   logic [N_DIGITS-1:0]   anodes_nxt;

   always_comb begin
      slot_wrap        = running && (cnt == CNT_LAST);
      frame_wrap       = slot_wrap && (idx == IDX_LAST);
      commit           = frame_wrap && pending_full;
      accept           = data_valid && data_ready;
      cnt_nxt          = (!running || slot_wrap) ? '0 : cnt + 1'b1;
      idx_nxt          = idx;
      if (!running || frame_wrap) idx_nxt = '0;
      else if (slot_wrap)         idx_nxt = idx + 1'b1;
      active_nxt       = commit ? pending : active;
      pending_full_nxt = pending_full;
      if (commit)      pending_full_nxt = 1'b0;
      else if (accept) pending_full_nxt = 1'b1;
      // Every slot opens in BLANK unless there is no dead-time at all.
      state_nxt = state;
      if (!running || slot_wrap)  state_nxt = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
      else if (cnt_nxt == BLANK_C) state_nxt = ST_DRIVE;
   end

`ifdef DISPLAY_SCAN_LZB_EN
   logic zero_above;
   always_comb begin
      zero_above = 1'b1;
      supp       = '0;
      for (int i = N_DIGITS - 1; i >= 1; i--) begin
         zero_above = zero_above && (active_nxt[4*i +: 4] == 4'd0);
         supp[i]    = zero_above;
      end
   end
`else
   assign supp = '0;
`endif

   assign anodes_nxt = (state_nxt == ST_DRIVE && !supp[idx_nxt])
                       ? ~(N_DIGITS'(1) << idx_nxt) : '1;

   always_ff @(posedge clk) begin
      if (rst) begin
         running      <= 1'b0;
         cnt          <= '0;
         idx          <= '0;
         state        <= ST_BLANK;
         active       <= '0;
         pending      <= '0;
         pending_full <= 1'b0;
         data_ready   <= 1'b0;
         digit_code   <= 4'd0;
         anodes       <= '1;
         frame_start  <= 1'b0;
      end else begin
         running      <= 1'b1;
         cnt          <= cnt_nxt;
         idx          <= idx_nxt;
         state        <= state_nxt;
         active       <= active_nxt;
         if (accept) pending <= data_in;
         pending_full <= pending_full_nxt;
         data_ready   <= ~pending_full_nxt;
         digit_code   <= active_nxt[{idx_nxt, 2'b00} +: 4];
         anodes       <= anodes_nxt;
         frame_start  <= (cnt_nxt == '0) && (idx_nxt == '0);
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl (4 digits, 8-cycle slots, 2 blank cycles): directed
// scenarios plus random traffic checked against a time-indexed behavioural model.
module tb_display_scan_ctrl;

   localparam int N  = 4;
   localparam int RD = 8;
   localparam int BC = 2;
   localparam int FRAME = N * RD;

   logic          clk = 1'b0;
   logic          rst;
   logic [4*N-1:0] data_in;
   logic          data_valid;
   logic          data_ready;
   logic [3:0]    digit_code;
   logic [N-1:0]  anodes;
   logic          frame_start;

   display_scan_ctrl #(.N_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
      .data_ready(data_ready), .digit_code(digit_code), .anodes(anodes),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Model: cycles since scanning started, displayed word, pending words.
   logic           m_run = 1'b0;
   int             m_t = 0;
   logic [15:0]    m_active = '0;
   logic [15:0]    exp_q[$];
   logic           m_accepted;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, obs, exp);
   endtask

   function automatic logic suppressed(input int i);
`ifdef DISPLAY_SCAN_LZB_EN
      return (i > 0) && ((m_active >> (4*i)) == 16'd0);
`else
      return 1'b0;
`endif
   endfunction

   task automatic check_outputs();
      logic [3:0] e_an, e_code;
      logic       e_fs, e_rdy;
      int cnt, idx;
      if (!m_run) begin
         e_an = 4'hF; e_code = 4'h0; e_fs = 1'b0; e_rdy = 1'b0;
      end else begin
         cnt    = m_t % RD;
         idx    = (m_t / RD) % N;
         e_code = 4'((m_active >> (4*idx)) & 16'hF);
         e_an   = (cnt >= BC && !suppressed(idx)) ? 4'(4'hF ^ (1 << idx)) : 4'hF;
         e_fs   = (m_t % FRAME) == 0;
         e_rdy  = (exp_q.size() == 0);
      end
      check("anodes", 32'(anodes), 32'(e_an));
      check("digit_code", 32'(digit_code), 32'(e_code));
      check("frame_start", 32'(frame_start), 32'(e_fs));
      check("data_ready", 32'(data_ready), 32'(e_rdy));
      check("one_low", 32'($countones(~anodes) <= 1), 32'd1);
   endtask

   // One clock: check this cycle's outputs, drive inputs for the next edge, advance the model.
   task automatic cycle(input logic r, input logic v, input logic [15:0] d);
      @(negedge clk);
      check_outputs();
      rst = r; data_valid = v; data_in = d;
      m_accepted = 1'b0;
      if (r) begin
         m_run = 1'b0; m_t = 0; m_active = '0; exp_q.delete();
      end else if (!m_run) begin
         m_run = 1'b1; m_t = 0;
      end else begin
         if ((m_t % FRAME) == FRAME - 1 && exp_q.size() > 0) m_active = exp_q.pop_front();
         else if (v && exp_q.size() == 0) begin
            exp_q.push_back(d);
            m_accepted = 1'b1;
         end
         m_t++;
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 16'h0);
   endtask

   task automatic offer(input logic [15:0] d);
      int k;
      m_accepted = 1'b0;
      for (k = 0; k < 200 && !m_accepted; k++) cycle(1'b0, 1'b1, d);
      check("offer_accepted", 32'(m_accepted), 32'd1);
   endtask

   task automatic do_reset(input int n);
      for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 16'h0);
   endtask

   initial begin
      logic [15:0] words[3];
      rst = 1'b1; data_valid = 1'b0; data_in = '0;
      repeat (2) @(posedge clk);
      do_reset(3);

      // Load, commit and scan.
      idle(1);
      offer(16'h1234);
      idle(2 * FRAME);

      // Back-to-back loads with data_valid held high.
      offer(16'hAAAA);
      offer(16'h5555);
      idle(2 * FRAME);

      // Reset mid-frame with data still pending.
      offer(16'h1111);
      idle(FRAME - 2);
      offer(16'h9999);
      while (((m_t % FRAME) / RD) != 1) cycle(1'b0, 1'b0, 16'h0);
      idle(3);
      do_reset(1);
      idle(2 * FRAME);

      // Leading-zero patterns.
      words[0] = 16'h0042; words[1] = 16'h0000; words[2] = 16'h1000;
      for (int w = 0; w < 3; w++) begin
         offer(words[w]);
         idle(2 * FRAME);
      end

      // Random traffic with occasional resets.
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 499) == 0) cycle(1'b1, 1'b0, 16'h0);
         else cycle(1'b0, 1'($urandom_range(0, 1)), 16'($urandom));
      end
      idle(4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
